// File: rtl/pattern_gen.sv
// Table-driven pattern generator: plays the first len words of a writable table,
// once with a done pulse or repeatedly, with registered outputs.
module pattern_gen #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr_en,
   input  logic [$clog2(DEPTH)-1:0]   wr_addr,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic [$clog2(DEPTH+1)-1:0] len,
   input  logic                       loop,
   input  logic                       start,
   input  logic                       stop,
   output logic [WIDTH-1:0]           pat_out,
   output logic                       pat_valid,
   output logic                       busy,
   output logic                       done
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH + 1);

   typedef enum logic {IDLE, PLAY} state_e;

   state_e           state_q, state_d;
   logic [AW-1:0]    idx_q, idx_d;
   logic [LW-1:0]    len_q, len_d;
   logic             loop_q, loop_d;
   logic [WIDTH-1:0] pat_q, pat_d;
   logic             valid_q, valid_d;
   logic             done_q, done_d;
   logic             rst_start_q;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [LW-1:0]    len_clamped;
   logic             start_ok;
   logic             last;

   // NOTE: the table and the reset-start tracker have no reset; a reset port on a
   // RAM array defeats memory inference and the table is only defined after writes.
   always_ff @(posedge clk) begin
      if (wr_en && (32'(wr_addr) < 32'(DEPTH)))
         mem[wr_addr] <= wr_data;
      // Remembers that start was already high while reset was held, so that the
      // first edge after release does not mistake it for a fresh request.
      rst_start_q <= !rst_n && start;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the values from before the edge regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         len_q   <= '0;
         loop_q  <= 1'b0;
         pat_q   <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         loop_q  <= loop_d;
         pat_q   <= pat_d;
         valid_q <= valid_d;
         done_q  <= done_d;
      end
   end

   assign len_clamped = (32'(len) > 32'(DEPTH)) ? LW'(DEPTH) : len;
   assign start_ok    = start && !stop && (len != '0) && !rst_start_q;
   assign last        = (LW'(idx_q) + LW'(1)) == len_q;

   // NOTE: every signal written here gets a default first, so no path can
   // leave a value held and infer a latch.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      len_d   = len_q;
      loop_d  = loop_q;
      valid_d = 1'b0;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_ok) begin
               state_d = PLAY;
               len_d   = len_clamped;
               loop_d  = loop;
               idx_d   = '0;
               valid_d = 1'b1;
            end
         end
         PLAY: begin
            if (stop) begin
               state_d = IDLE;
               idx_d   = '0;
            end else if (last && !loop_q) begin
               state_d = IDLE;
               idx_d   = '0;
               done_d  = 1'b1;
            end else begin
               idx_d   = last ? '0 : idx_q + AW'(1);
               valid_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      // The read uses the table contents before this edge's write: read-before-write.
      pat_d = valid_d ? mem[idx_d] : '0;
   end

   always_comb begin
      pat_out   = pat_q;
      pat_valid = valid_q;
      busy      = (state_q == PLAY);
      done      = done_q;
   end

endmodule

// File: doc/pattern_gen.md
PATTERN_GEN -- requirements
Module: pattern_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8, pattern word width in bits (1..64).
REQ-002 SHALL have parameter DEPTH, default 16, pattern table entries (2..256).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 SHALL have port wr_en  input  1  table write strobe.
REQ-006 SHALL have port wr_addr  input  $clog2(DEPTH)  table write address.
REQ-007 SHALL have port wr_data  input  WIDTH  table write data.
REQ-008 SHALL have port len  input  $clog2(DEPTH+1)  number of entries to play, sampled at start.
REQ-009 SHALL have port loop  input  1  repeat mode, sampled at start.
REQ-010 SHALL have port start  input  1  begin playback request.
REQ-011 SHALL have port stop  input  1  abort playback request.
REQ-012 SHALL have port pat_out  output  WIDTH  registered pattern word.
REQ-013 SHALL have port pat_valid  output  1  pat_out holds a table word this cycle.
REQ-014 SHALL have port busy  output  1  high in PLAY state.
REQ-015 SHALL have port done  output  1  one-cycle pulse on normal completion.

Function
REQ-016 SHALL implement states IDLE and PLAY; busy = (state == PLAY).
REQ-017 SHALL, in IDLE, on an edge with start=1, stop=0, len!=0: latch len (clamped to DEPTH) and loop, set idx=0, enter PLAY.
REQ-018 SHALL ignore start when len==0, when stop=1, or when already in PLAY.
REQ-019 SHALL present pat_out=table[idx] with pat_valid=1 on the edge that enters PLAY and on each subsequent PLAY edge; first word is valid one cycle after start is sampled.
REQ-020 SHALL advance idx by 1 per cycle in PLAY; no stall/backpressure.
REQ-021 SHALL, when idx==len_latched-1 and loop_latched=0, output the last word, then return to IDLE on the next edge with done=1 for exactly that one cycle.
REQ-022 SHALL, when idx==len_latched-1 and loop_latched=1, wrap idx to 0 with no gap cycle and never assert done.
REQ-023 SHALL, on an edge with stop=1 in PLAY, enter IDLE with pat_valid=0 that cycle and no done pulse; stop overrides wrap and last-entry completion on the same edge.
REQ-024 SHALL drive pat_out=0 whenever pat_valid=0.
REQ-025 SHALL write wr_data into table[wr_addr] on any edge with wr_en=1, in either state; wr_addr>=DEPTH SHALL be ignored.
REQ-026 SHALL give read-before-write: a write to the address read on the same edge yields the old word on pat_out, the new word on the next visit.
REQ-027 SHALL ignore changes to len and loop during PLAY.
REQ-028 SHALL support len==1: non-loop gives one valid cycle then done; loop repeats table[0] every cycle.

Reset
REQ-029 SHALL, on rst_n=0, immediately and asynchronously force state=IDLE, idx=0, pat_out=0, pat_valid=0, busy=0, done=0, including mid-playback.
REQ-030 SHALL leave table contents unreset; table is defined only after writes.
REQ-031 SHALL ignore start on the first edge after rst_n deasserts only if start was already high during reset; otherwise normal operation resumes on the first edge.

Verification
REQ-032 Write table[0..3]=8'hA0..8'hA3, len=4, loop=0, pulse start -> pat_out A0,A1,A2,A3 on consecutive cycles, pat_valid=1 for 4 cycles, done=1 on the 5th cycle, busy=0 after.
REQ-033 Same table, len=3, loop=1 -> A0,A1,A2,A0,A1,... without gaps; stop asserted after 7 words -> pat_valid=0 and busy=0 next cycle, done never 1.
REQ-034 len=0 with start, and start while busy -> no state change; pat_valid unchanged, no done.
REQ-035 During playback len=4, write table[2]=8'h5A on the edge that reads index 2 -> pat_out A2 that cycle; with loop=1, 5A on the next pass.
REQ-036 Drop rst_n mid-playback between clock edges -> pat_out=0, pat_valid=0, busy=0 without waiting for a clock edge; table data retained and replays correctly after reset.
REQ-037 WIDTH=1, DEPTH=2 and WIDTH=16, DEPTH=256 builds: len=DEPTH non-loop playback yields DEPTH words then a single done pulse; len>DEPTH clamps to DEPTH.
